adaptimer2_s_axi_timer: RTL and testbench
=========================================

Name: adaptimer2_s_axi_timer

Overview:
AXI4-Lite slave stage of AdapTimer2. It sits directly downstream of the AXI4-Lite master BFM and terminates every S_AXI transaction. It provides four read/write registers at 0x00-0x0C and read-only timer count/status at 0x10-0x14. It also contains the prescaled timer counter and its interrupt output.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; bits [4:2] select the register.

Ports:
ACLK  in  1  single clock; all state updates on the rising edge
ARESETN  in  1  asynchronous, active-low reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accepted
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accepted
S_AXI_BRESP  out  2  write response; always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response accepted
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accepted
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response; always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data accepted
timer_irq  out  1  level interrupt = STATUS[0] & CTRL[1]

Behaviour:
Reset:
- ARESETN low forces every register, counter, READY and VALID to 0 immediately, independent of ACLK.
- RDATA=0, timer_irq=0 during reset.
- Reset asserted mid-transaction aborts that transaction; no response is issued after reset release.

Register map (word index = ADDR[4:2]):
- 0 CTRL: R/W, all 32 bits stored. [0] enable, [1] irq enable, [15:8] prescale.
- 1 PERIOD: R/W.
- 2 COMPARE: R/W storage, no timer effect.
- 3 SCRATCH: R/W.
- 4 COUNT: RO.
- 5 STATUS: [0] period event; write-1-to-clear on byte lane 0; other bits read 0.
- 6-7: unmapped. Writes are ignored and reads return 0, both with OKAY.

Write channel:
- At cycle N the slave samples AWVALID=1 and WVALID=1 with awready=0 and BVALID=0.
- AWREADY and WREADY are both 1 for exactly cycle N+1; the register write occurs at the end of cycle N+1.
- BVALID=1 from cycle N+2 and is held until BREADY=1.
- No new AW/W is accepted while BVALID=1. AW without W, or W without AW, is left stalled.
- WSTRB[i] gates byte i. WSTRB=0 produces a response with no register change.

Read channel:
- At cycle N the slave samples ARVALID=1 with arready=0 and RVALID=0.
- ARREADY=1 for exactly cycle N+1, and the address is latched.
- RVALID=1 from cycle N+2, RDATA registered from the latched address.
- RDATA and RVALID are held stable until RREADY=1.
- Reads and writes proceed independently and concurrently.

Timer:
- With CTRL[0]=1, the 8-bit prescaler increments each cycle.
- When prescaler==CTRL[15:8], the prescaler returns to 0 and a tick occurs, i.e. one tick every prescale+1 cycles.
- On tick, if COUNT>=PERIOD then COUNT<=0 and STATUS[0]<=1; otherwise COUNT<=COUNT+1.
- PERIOD=0 gives an event on every tick.
- Writing PERIOD below the current COUNT wraps on the next tick.
- CTRL[0]=0 holds the prescaler and COUNT; they resume on re-enable.
- Writing CTRL with [0]=0 resets the prescaler to 0.
- A STATUS W1C and a new event in the same cycle leave STATUS[0]=1 (the event wins).
- A COUNT read returns the value at the ARREADY cycle.

Test Plan:
- Register readback: write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x00, 0x04, 0x08, 0x0C in turn, reading each back -> read data matches exactly; BRESP=RRESP=00.
- Partial strobe: SCRATCH=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> readback 0xFF34FF78.
- Unmapped and RO addresses: write 0xA5A5A5A5 to 0x18 and 0x10 -> BRESP=00. Read 0x18 -> 0x00000000; COUNT unchanged.
- Timer event: PERIOD=3, CTRL=0x00000003 -> STATUS[0] and timer_irq rise 4 cycles after the CTRL write completes (ticks set COUNT 1,2,3,0). Prescale=1 -> 8 cycles. W1C 0x1 to 0x14 -> timer_irq falls.
- Collision and backpressure: W1C coincident with an event -> STATUS[0] stays 1. BREADY/RREADY held low 5 cycles -> BVALID/RVALID and RDATA stay stable, and a second AW/W is not accepted.
- Reset mid-write: drop ARESETN while BVALID=1 -> BVALID, COUNT, CTRL and timer_irq go 0 asynchronously. After release, reads of 0x00 and 0x10 return 0.

Source files
------------

// File: rtl/adaptimer2_s_axi_timer_if.sv
// AXI4-Lite bus bundle between the AdapTimer2 master BFM and the timer slave.
// The master modport drives requests and the slave modport drives responses.
interface adaptimer2_s_axi_timer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/adaptimer2_s_axi_timer.sv
// AdapTimer2 AXI4-Lite slave: CTRL/PERIOD/COMPARE/SCRATCH registers, read-only
// COUNT/STATUS, and the prescaled period timer that drives timer_irq.
module adaptimer2_s_axi_timer #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   adaptimer2_s_axi_timer_if.slave        s_axi,
   output logic                           timer_irq
);
   localparam logic [2:0] IDX_CTRL    = 3'd0;
   localparam logic [2:0] IDX_PERIOD  = 3'd1;
   localparam logic [2:0] IDX_COMPARE = 3'd2;
   localparam logic [2:0] IDX_SCRATCH = 3'd3;
   localparam logic [2:0] IDX_COUNT   = 3'd4;
   localparam logic [2:0] IDX_STATUS  = 3'd5;

   logic        awready_r, wready_r, bvalid_r;
   logic        arready_r, rvalid_r;
   logic [31:0] rdata_r;
   logic [31:0] ctrl_r, period_r, compare_r, scratch_r, count_r;
   logic [7:0]  prescale_r;
   logic        status_r, irq_r;

   logic [31:0] ctrl_nxt_s, period_nxt_s, compare_nxt_s, scratch_nxt_s, count_nxt_s;
   logic [7:0]  prescale_nxt_s;
   logic        status_nxt_s, tick_s, event_s, w1c_s;
   logic        wr_fire_s;
   logic [2:0]  wr_idx_s, rd_idx_s;
   logic [31:0] rd_mux_s;
   logic        unused_ok_s;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   // Ready pulses only while the master still holds both valids, so this is the write edge.
   assign wr_fire_s   = awready_r & wready_r & s_axi.awvalid & s_axi.wvalid;
   assign wr_idx_s    = s_axi.awaddr[4:2];
   assign rd_idx_s    = s_axi.araddr[4:2];
   assign unused_ok_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   // Write address/data acceptance and the held write response.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
      end else begin
         if (awready_r) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
         end else if (s_axi.awvalid && s_axi.wvalid && !bvalid_r) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
         end
         if (wr_fire_s) begin
            bvalid_r <= 1'b1;
         end else if (bvalid_r && s_axi.bready) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   // Read data selection; COUNT is sampled during the ARREADY cycle.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (rd_idx_s)
         IDX_CTRL:    rd_mux_s = ctrl_r;
         IDX_PERIOD:  rd_mux_s = period_r;
         IDX_COMPARE: rd_mux_s = compare_r;
         IDX_SCRATCH: rd_mux_s = scratch_r;
         IDX_COUNT:   rd_mux_s = count_r;
         IDX_STATUS:  rd_mux_s = {31'd0, status_r};
         default:     rd_mux_s = 32'h0000_0000;
      endcase
   end

   // Read address acceptance and the held read data beat.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'h0000_0000;
      end else begin
         if (arready_r) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_mux_s;
         end else if (s_axi.arvalid && !rvalid_r) begin
            arready_r <= 1'b1;
         end else if (rvalid_r && s_axi.rready) begin
            rvalid_r  <= 1'b0;
         end
      end
   end

   // Next-state for the register file, prescaler, counter and period event.
   always_comb begin
      ctrl_nxt_s     = ctrl_r;
      period_nxt_s   = period_r;
      compare_nxt_s  = compare_r;
      scratch_nxt_s  = scratch_r;
      prescale_nxt_s = prescale_r;
      count_nxt_s    = count_r;
      tick_s         = 1'b0;
      event_s        = 1'b0;
      w1c_s          = 1'b0;

      if (ctrl_r[0]) begin
         if (prescale_r == ctrl_r[15:8]) begin
            prescale_nxt_s = 8'd0;
            tick_s         = 1'b1;
         end else begin
            prescale_nxt_s = prescale_r + 8'd1;
         end
      end else begin
         prescale_nxt_s = prescale_r;
      end

      if (tick_s) begin
         if (count_r >= period_r) begin
            count_nxt_s = 32'd0;
            event_s     = 1'b1;
         end else begin
            count_nxt_s = count_r + 32'd1;
         end
      end else begin
         count_nxt_s = count_r;
      end

      if (wr_fire_s) begin
         case (wr_idx_s)
            IDX_CTRL: begin
               ctrl_nxt_s = merge_bytes(ctrl_r, s_axi.wdata, s_axi.wstrb);
               if (!ctrl_nxt_s[0]) begin
                  prescale_nxt_s = 8'd0;
               end else begin
                  prescale_nxt_s = prescale_nxt_s;
               end
            end
            IDX_PERIOD:  period_nxt_s  = merge_bytes(period_r, s_axi.wdata, s_axi.wstrb);
            IDX_COMPARE: compare_nxt_s = merge_bytes(compare_r, s_axi.wdata, s_axi.wstrb);
            IDX_SCRATCH: scratch_nxt_s = merge_bytes(scratch_r, s_axi.wdata, s_axi.wstrb);
            IDX_STATUS:  w1c_s         = s_axi.wstrb[0] & s_axi.wdata[0];
            default:     w1c_s         = 1'b0;
         endcase
      end else begin
         w1c_s = 1'b0;
      end

      // A fresh period event outranks a coincident clear.
      if (event_s) begin
         status_nxt_s = 1'b1;
      end else if (w1c_s) begin
         status_nxt_s = 1'b0;
      end else begin
         status_nxt_s = status_r;
      end
   end

   // Timer and register state, with the interrupt registered from next-state values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ctrl_r     <= 32'd0;
         period_r   <= 32'd0;
         compare_r  <= 32'd0;
         scratch_r  <= 32'd0;
         count_r    <= 32'd0;
         prescale_r <= 8'd0;
         status_r   <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         ctrl_r     <= ctrl_nxt_s;
         period_r   <= period_nxt_s;
         compare_r  <= compare_nxt_s;
         scratch_r  <= scratch_nxt_s;
         count_r    <= count_nxt_s;
         prescale_r <= prescale_nxt_s;
         status_r   <= status_nxt_s;
         irq_r      <= status_nxt_s & ctrl_nxt_s[1];
      end
   end

   assign s_axi.awready = awready_r;
   assign s_axi.wready  = wready_r;
   assign s_axi.bvalid  = bvalid_r;
   assign s_axi.bresp   = 2'b00;
   assign s_axi.arready = arready_r;
   assign s_axi.rvalid  = rvalid_r;
   assign s_axi.rdata   = rdata_r;
   assign s_axi.rresp   = 2'b00;
   assign timer_irq     = irq_r;
endmodule

// File: tb/tb_adaptimer2_s_axi_timer.sv
// Directed bench for the AdapTimer2 AXI4-Lite timer slave; expected values are
// worked out by hand from the register map and timer arithmetic.
module tb_adaptimer2_s_axi_timer;
   logic tb_ACLK    = 1'b0;
   logic tb_ARESETN = 1'b0;
   logic timer_irq;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] rd_v;

   always #5 tb_ACLK = ~tb_ACLK;

   adaptimer2_s_axi_timer_if #(.ADDR_W(5), .DATA_W(32)) axi_if ();

   adaptimer2_s_axi_timer #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(5)
   ) dut (
      .ACLK      (tb_ACLK),
      .ARESETN   (tb_ARESETN),
      .s_axi     (axi_if.slave),
      .timer_irq (timer_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge tb_ACLK);
         #1;
      end
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string tag);
      logic got;
      axi_if.awaddr  = addr;
      axi_if.wdata   = data;
      axi_if.wstrb   = strb;
      axi_if.awvalid = 1'b1;
      axi_if.wvalid  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc(1);
         got = axi_if.awready & axi_if.wready;
      end
      check({tag, "_awready"}, 32'(got), 32'd1);
      cyc(1);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      check({tag, "_bvalid_bresp"}, 32'({axi_if.bvalid, axi_if.bresp}), 32'h0000_0004);
      cyc(1);
   endtask

   task automatic axi_read(input logic [4:0] addr, input string tag, output logic [31:0] data);
      logic got;
      axi_if.araddr  = addr;
      axi_if.arvalid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc(1);
         got = axi_if.arready;
      end
      check({tag, "_arready"}, 32'(got), 32'd1);
      cyc(1);
      axi_if.arvalid = 1'b0;
      check({tag, "_rvalid_rresp"}, 32'({axi_if.rvalid, axi_if.rresp}), 32'h0000_0004);
      data = axi_if.rdata;
      cyc(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rb_val [4];
      rb_val = '{32'h0101_FFFF, 32'hABCD_0001, 32'hDEAD_0011, 32'hBEEF_0011};
      axi_if.awaddr = 5'd0;  axi_if.awprot = 3'd0; axi_if.awvalid = 1'b0;
      axi_if.wdata  = 32'd0; axi_if.wstrb  = 4'd0; axi_if.wvalid  = 1'b0;
      axi_if.bready = 1'b1;
      axi_if.araddr = 5'd0;  axi_if.arprot = 3'd0; axi_if.arvalid = 1'b0;
      axi_if.rready = 1'b1;

      #1;
      check("reset_handshake", 32'({axi_if.awready, axi_if.wready, axi_if.bvalid,
                                     axi_if.arready, axi_if.rvalid, timer_irq}), 32'd0);
      check("reset_rdata", axi_if.rdata, 32'd0);
      cyc(3);
      tb_ARESETN = 1'b1;
      cyc(2);

      // Register write/readback
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(i * 4), rb_val[i], 4'hF, "rb_wr");
         axi_read(5'(i * 4), "rb_rd", rd_v);
         check("rb_data", rd_v, rb_val[i]);
      end
      axi_write(5'h00, 32'h0000_0000, 4'hF, "ctrl_stop");

      // Partial strobe
      axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, "scr_ones");
      axi_write(5'h0C, 32'h1234_5678, 4'b0101, "scr_strb");
      axi_read(5'h0C, "scr_rd", rd_v);
      check("partial_strobe", rd_v, 32'hFF34_FF78);

      // Unmapped and read-only targets
      axi_write(5'h18, 32'hA5A5_A5A5, 4'hF, "unmapped_wr");
      axi_write(5'h10, 32'hA5A5_A5A5, 4'hF, "count_wr");
      axi_read(5'h18, "unmapped_rd", rd_v);
      check("unmapped_data", rd_v, 32'd0);
      axi_read(5'h1C, "unmapped7_rd", rd_v);
      check("unmapped7_data", rd_v, 32'd0);
      axi_read(5'h10, "count_rd", rd_v);
      check("count_unchanged", rd_v, 32'd0);

      // Timer, prescale 0: ticks every cycle, event four edges after CTRL write
      axi_write(5'h04, 32'd3, 4'hF, "per3");
      axi_write(5'h00, 32'h0000_0003, 4'hF, "ctrl_en");
      cyc(2);
      check("irq_before_evt", 32'(timer_irq), 32'd0);
      cyc(1);
      check("irq_evt_ps0", 32'(timer_irq), 32'd1);
      axi_read(5'h14, "status_rd", rd_v);
      check("status_set", rd_v, 32'd1);

      // Re-arm with COUNT=0 and prescale 1: event eight edges after CTRL write
      axi_write(5'h04, 32'd0, 4'hF, "per0");
      axi_write(5'h00, 32'h0000_0102, 4'hF, "ctrl_hold");
      axi_write(5'h04, 32'd3, 4'hF, "per3b");
      axi_write(5'h14, 32'd1, 4'h1, "w1c_a");
      check("irq_cleared_a", 32'(timer_irq), 32'd0);
      axi_write(5'h00, 32'h0000_0103, 4'hF, "ctrl_ps1");
      cyc(6);
      check("irq_before_ps1", 32'(timer_irq), 32'd0);
      cyc(1);
      check("irq_evt_ps1", 32'(timer_irq), 32'd1);
      axi_write(5'h14, 32'd1, 4'h1, "w1c_b");
      check("irq_cleared_b", 32'(timer_irq), 32'd0);

      // W1C lands on the same edge as the next event
      cyc(3);
      axi_write(5'h14, 32'd1, 4'h1, "w1c_coll");
      check("irq_collision", 32'(timer_irq), 32'd1);
      axi_read(5'h14, "status_coll_rd", rd_v);
      check("status_collision", rd_v, 32'd1);

      // Write-response backpressure with a second write queued
      axi_if.bready  = 1'b0;
      axi_if.awaddr  = 5'h0C;
      axi_if.wdata   = 32'h1122_3344;
      axi_if.wstrb   = 4'hF;
      axi_if.awvalid = 1'b1;
      axi_if.wvalid  = 1'b1;
      cyc(1);
      check("bp_awready", 32'(axi_if.awready), 32'd1);
      cyc(1);
      axi_if.wdata = 32'h5566_7788;
      check("bp_bvalid", 32'(axi_if.bvalid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("bp_hold", 32'({axi_if.bvalid, axi_if.awready, axi_if.wready}), 32'h0000_0004);
      end
      axi_if.bready = 1'b1;
      cyc(1);
      check("bp_released", 32'(axi_if.bvalid), 32'd0);
      cyc(1);
      check("bp_second_aw", 32'(axi_if.awready), 32'd1);
      cyc(1);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      check("bp_second_b", 32'(axi_if.bvalid), 32'd1);
      cyc(1);
      axi_read(5'h0C, "bp_rd", rd_v);
      check("bp_second_data", rd_v, 32'h5566_7788);

      // Read-data backpressure while SCRATCH is overwritten
      axi_if.rready  = 1'b0;
      axi_if.araddr  = 5'h0C;
      axi_if.arvalid = 1'b1;
      cyc(1);
      check("rbp_arready", 32'(axi_if.arready), 32'd1);
      cyc(1);
      axi_if.arvalid = 1'b0;
      check("rbp_rvalid", 32'(axi_if.rvalid), 32'd1);
      axi_write(5'h0C, 32'h0BAD_F00D, 4'hF, "rbp_wr");
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("rbp_hold_valid", 32'(axi_if.rvalid), 32'd1);
         check("rbp_hold_data", axi_if.rdata, 32'h5566_7788);
      end
      axi_if.rready = 1'b1;
      cyc(1);
      check("rbp_released", 32'(axi_if.rvalid), 32'd0);

      // Reset while a write response is pending
      axi_if.bready  = 1'b0;
      axi_if.awaddr  = 5'h04;
      axi_if.wdata   = 32'd5;
      axi_if.wstrb   = 4'hF;
      axi_if.awvalid = 1'b1;
      axi_if.wvalid  = 1'b1;
      cyc(1);
      check("rst_awready", 32'(axi_if.awready), 32'd1);
      cyc(1);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      check("rst_pre_bvalid", 32'(axi_if.bvalid), 32'd1);
      check("rst_pre_irq", 32'(timer_irq), 32'd1);
      #2;
      tb_ARESETN = 1'b0;
      #1;
      check("rst_async_outs", 32'({axi_if.bvalid, timer_irq, axi_if.awready, axi_if.rvalid}), 32'd0);
      check("rst_async_rdata", axi_if.rdata, 32'd0);
      check("rst_async_count", dut.count_r, 32'd0);
      check("rst_async_ctrl", dut.ctrl_r, 32'd0);
      axi_if.bready = 1'b1;
      cyc(2);
      tb_ARESETN = 1'b1;
      cyc(2);
      check("rst_no_bresp", 32'(axi_if.bvalid), 32'd0);
      axi_read(5'h00, "rst_ctrl_rd", rd_v);
      check("rst_ctrl_zero", rd_v, 32'd0);
      axi_read(5'h10, "rst_count_rd", rd_v);
      check("rst_count_zero", rd_v, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
